// File: rtl/shift_register_unloader_if.sv
// Handshake and data bundle between a snapshot source/sink and the unloader.
interface shift_register_unloader_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned SIZE  = 8
);
    logic                    load;
    logic [WIDTH*SIZE-1:0]   data_in;
    logic                    out_ready;
    logic                    out_valid;
    logic [WIDTH-1:0]        data_out;
    logic                    out_last;
    logic                    busy;
    logic                    done;

    // Side that requests snapshots and consumes the serial stream.
    modport master (
        output load,
        output data_in,
        output out_ready,
        input  out_valid,
        input  data_out,
        input  out_last,
        input  busy,
        input  done
    );

    // The unloader itself.
    modport slave (
        input  load,
        input  data_in,
        input  out_ready,
        output out_valid,
        output data_out,
        output out_last,
        output busy,
        output done
    );
endinterface

// File: rtl/shift_register_unloader.sv
// Parallel-in, serial-out unloader: snapshots SIZE samples and streams them
// oldest-first over a valid/ready handshake, flagging the last and pulsing done.
module shift_register_unloader #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned SIZE  = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    shift_register_unloader_if.slave       bus
);
    localparam int unsigned IDX_W = (SIZE > 1) ? $clog2(SIZE) : 1;

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t                       state;
    logic [SIZE-1:0][WIDTH-1:0]   snap;
    logic [IDX_W-1:0]             idx;

    // Sequencer: capture on load in IDLE, then walk idx down to 0 per transfer.
    // Outputs are computed one edge ahead so they stay purely registered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            snap          <= '0;
            idx           <= '0;
            bus.out_valid <= 1'b0;
            bus.data_out  <= '0;
            bus.out_last  <= 1'b0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.load) begin
                        snap          <= bus.data_in;
                        idx           <= IDX_W'(SIZE - 1);
                        state         <= SEND;
                        bus.out_valid <= 1'b1;
                        bus.busy      <= 1'b1;
                        bus.data_out  <= bus.data_in[(SIZE-1)*WIDTH +: WIDTH];
                        bus.out_last  <= 1'b0;
                    end
                end
                SEND: begin
                    if (bus.out_ready) begin
                        if (idx == '0) begin
                            state         <= IDLE;
                            bus.out_valid <= 1'b0;
                            bus.busy      <= 1'b0;
                            bus.data_out  <= '0;
                            bus.out_last  <= 1'b0;
                            bus.done      <= 1'b1;
                        end else begin
                            idx           <= idx - IDX_W'(1);
                            bus.data_out  <= snap[idx - IDX_W'(1)];
                            bus.out_last  <= (idx == IDX_W'(1));
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_shift_register_unloader.sv
// Directed self-checking bench for shift_register_unloader (WIDTH=8, SIZE=8).
module tb_shift_register_unloader;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned SIZE  = 8;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   passed = 0;

    // Expected stream when out_ready is low for stream cycles 2..4.
    logic [7:0] bp_seq [11] = '{8'h17, 8'h16, 8'h16, 8'h16, 8'h16,
                                8'h15, 8'h14, 8'h13, 8'h12, 8'h11, 8'h10};

    shift_register_unloader_if #(.WIDTH(WIDTH), .SIZE(SIZE)) bus ();

    shift_register_unloader #(.WIDTH(WIDTH), .SIZE(SIZE)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Snapshot with element i = base + i.
    function automatic logic [WIDTH*SIZE-1:0] mk(input logic [7:0] base);
        logic [WIDTH*SIZE-1:0] v;
        v = '0;
        for (int i = 0; i < SIZE; i++) v[i*WIDTH +: WIDTH] = base + 8'(i);
        return v;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        bus.load = 1'b1;
        bus.data_in = {SIZE{8'h55}};
        bus.out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            checks++; if (bus.out_valid !== 1'b0) $display("FAIL reset_valid cyc%0d got %b want 0", c, bus.out_valid); else passed++;
            checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy cyc%0d got %b want 0", c, bus.busy); else passed++;
            checks++; if (bus.done !== 1'b0) $display("FAIL reset_done cyc%0d got %b want 0", c, bus.done); else passed++;
            checks++; if (bus.data_out !== 8'h00) $display("FAIL reset_data cyc%0d got %h want 00", c, bus.data_out); else passed++;
        end
        bus.load = 1'b0;
        rst_n = 1'b1;
        step();
        checks++; if (bus.out_valid !== 1'b0) $display("FAIL reset_nocapture got %b want 0", bus.out_valid); else passed++;
    endtask

    task automatic test_basic();
        bus.load = 1'b1;
        bus.data_in = mk(8'h10);
        bus.out_ready = 1'b1;
        step();
        bus.load = 1'b0;
        for (int k = 0; k < 8; k++) begin
            checks++; if (bus.out_valid !== 1'b1) $display("FAIL basic_valid k%0d got %b want 1", k, bus.out_valid); else passed++;
            checks++; if (bus.data_out !== 8'(8'h17 - k)) $display("FAIL basic_data k%0d got %h want %h", k, bus.data_out, 8'(8'h17 - k)); else passed++;
            checks++; if (bus.out_last !== (k == 7)) $display("FAIL basic_last k%0d got %b want %b", k, bus.out_last, (k == 7)); else passed++;
            checks++; if (bus.busy !== 1'b1) $display("FAIL basic_busy k%0d got %b want 1", k, bus.busy); else passed++;
            checks++; if (bus.done !== 1'b0) $display("FAIL basic_early_done k%0d got %b want 0", k, bus.done); else passed++;
            step();
        end
        checks++; if (bus.done !== 1'b1) $display("FAIL basic_done got %b want 1", bus.done); else passed++;
        checks++; if (bus.busy !== 1'b0) $display("FAIL basic_busy_end got %b want 0", bus.busy); else passed++;
        checks++; if (bus.out_valid !== 1'b0) $display("FAIL basic_valid_end got %b want 0", bus.out_valid); else passed++;
        step();
        checks++; if (bus.done !== 1'b0) $display("FAIL basic_done_pulse got %b want 0", bus.done); else passed++;
    endtask

    task automatic test_backpressure();
        bus.load = 1'b1;
        bus.data_in = mk(8'h10);
        bus.out_ready = 1'b1;
        step();
        bus.load = 1'b0;
        for (int c = 1; c <= 11; c++) begin
            bus.out_ready = !(c >= 2 && c <= 4);
            checks++; if (bus.out_valid !== 1'b1) $display("FAIL bp_valid c%0d got %b want 1", c, bus.out_valid); else passed++;
            checks++; if (bus.data_out !== bp_seq[c-1]) $display("FAIL bp_data c%0d got %h want %h", c, bus.data_out, bp_seq[c-1]); else passed++;
            checks++; if (bus.out_last !== (c == 11)) $display("FAIL bp_last c%0d got %b want %b", c, bus.out_last, (c == 11)); else passed++;
            checks++; if (bus.done !== 1'b0) $display("FAIL bp_early_done c%0d got %b want 0", c, bus.done); else passed++;
            step();
        end
        bus.out_ready = 1'b1;
        checks++; if (bus.done !== 1'b1) $display("FAIL bp_done got %b want 1", bus.done); else passed++;
        step();
    endtask

    task automatic test_load_busy();
        bus.load = 1'b1;
        bus.data_in = mk(8'h10);
        bus.out_ready = 1'b1;
        step();
        bus.load = 1'b0;
        for (int k = 0; k < 8; k++) begin
            bus.load = (k == 3 || k == 7);
            if (bus.load) bus.data_in = {SIZE{8'hAA}};
            checks++; if (bus.data_out !== 8'(8'h17 - k)) $display("FAIL lb_data k%0d got %h want %h", k, bus.data_out, 8'(8'h17 - k)); else passed++;
            checks++; if (bus.out_last !== (k == 7)) $display("FAIL lb_last k%0d got %b want %b", k, bus.out_last, (k == 7)); else passed++;
            step();
        end
        bus.load = 1'b0;
        checks++; if (bus.done !== 1'b1) $display("FAIL lb_done got %b want 1", bus.done); else passed++;
        checks++; if (bus.out_valid !== 1'b0) $display("FAIL lb_valid_end got %b want 0", bus.out_valid); else passed++;
        step();
        checks++; if (bus.out_valid !== 1'b0) $display("FAIL lb_no_restart got %b want 0", bus.out_valid); else passed++;
    endtask

    task automatic test_back_to_back();
        bus.load = 1'b1;
        bus.data_in = mk(8'h10);
        bus.out_ready = 1'b1;
        step();
        bus.load = 1'b0;
        for (int k = 0; k < 8; k++) step();
        checks++; if (bus.done !== 1'b1) $display("FAIL b2b_first_done got %b want 1", bus.done); else passed++;
        bus.load = 1'b1;
        bus.data_in = mk(8'h20);
        step();
        bus.load = 1'b0;
        for (int k = 0; k < 8; k++) begin
            checks++; if (bus.out_valid !== 1'b1) $display("FAIL b2b_valid k%0d got %b want 1", k, bus.out_valid); else passed++;
            checks++; if (bus.data_out !== 8'(8'h27 - k)) $display("FAIL b2b_data k%0d got %h want %h", k, bus.data_out, 8'(8'h27 - k)); else passed++;
            step();
        end
        checks++; if (bus.done !== 1'b1) $display("FAIL b2b_second_done got %b want 1", bus.done); else passed++;
        step();
    endtask

    task automatic test_reset_mid();
        bus.load = 1'b1;
        bus.data_in = mk(8'h30);
        bus.out_ready = 1'b1;
        step();
        bus.load = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++; if (bus.data_out !== 8'(8'h37 - k)) $display("FAIL rm_data k%0d got %h want %h", k, bus.data_out, 8'(8'h37 - k)); else passed++;
            step();
        end
        rst_n = 1'b0;
        step();
        checks++; if (bus.out_valid !== 1'b0) $display("FAIL rm_valid got %b want 0", bus.out_valid); else passed++;
        checks++; if (bus.busy !== 1'b0) $display("FAIL rm_busy got %b want 0", bus.busy); else passed++;
        checks++; if (bus.done !== 1'b0) $display("FAIL rm_done got %b want 0", bus.done); else passed++;
        checks++; if (bus.data_out !== 8'h00) $display("FAIL rm_data_clr got %h want 00", bus.data_out); else passed++;
        rst_n = 1'b1;
        step();
        checks++; if (bus.done !== 1'b0) $display("FAIL rm_no_done got %b want 0", bus.done); else passed++;
        checks++; if (bus.out_valid !== 1'b0) $display("FAIL rm_idle got %b want 0", bus.out_valid); else passed++;
        bus.load = 1'b1;
        bus.data_in = mk(8'h40);
        step();
        bus.load = 1'b0;
        for (int k = 0; k < 8; k++) begin
            checks++; if (bus.data_out !== 8'(8'h47 - k)) $display("FAIL rm_fresh_data k%0d got %h want %h", k, bus.data_out, 8'(8'h47 - k)); else passed++;
            checks++; if (bus.out_last !== (k == 7)) $display("FAIL rm_fresh_last k%0d got %b want %b", k, bus.out_last, (k == 7)); else passed++;
            step();
        end
        checks++; if (bus.done !== 1'b1) $display("FAIL rm_fresh_done got %b want 1", bus.done); else passed++;
        step();
    endtask

    initial begin
        rst_n = 1'b0;
        bus.load = 1'b0;
        bus.data_in = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_load_busy();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
